// File: rtl/rxc_pkg.sv
// Shared definitions for the alink RX controller: state encoding, fill pattern, helpers.
// Build option ALINK_RXC_RR_EN selects round-robin arbitration (default: fixed priority).
package rxc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_RECV  = 2'b10,
        ST_FILL  = 2'b11
    } rxc_state_e;

    localparam int          PHY_NUM_DEF = 5;
    localparam logic [31:0] FILL_WORD   = 32'h0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rxc_arb.sv
// One-hot winner select for the RX controller. With ALINK_RXC_RR_EN defined the search
// starts after the last granted PHY; otherwise the lowest candidate index wins.
module rxc_arb #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [N-1:0] cand,
    input  logic         grant,
    output logic [N-1:0] win
);

`ifdef ALINK_RXC_RR_EN
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]  ptr;
    logic [PW-1:0]  win_idx;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] dbl_w;
    logic [N-1:0]   rot;
    logic [N-1:0]   pick;

    // Rotate candidates so ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        dbl   = {cand, cand} >> ptr;
        rot   = dbl[N-1:0];
        pick  = rot & (~rot + 1'b1);
        dbl_w = {pick, pick} << ptr;
        win   = dbl_w[2*N-1:N];
    end

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (win[i]) win_idx = PW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
        end
    end
`else
    logic unused_arb;
    assign unused_arb = ^{clk, rst, flush, grant};
    assign win        = cand & (~cand + 1'b1);
`endif

endmodule

// File: rtl/rxc.sv
// alink RX controller: grants one requesting PHY at a time into the shared RX FIFO and
// pads watchdog-cut frames with fill words. ALINK_RXC_RR_EN enables round-robin grants.
module rxc
    import rxc_pkg::*;
#(
    parameter int PHY_NUM  = PHY_NUM_DEF,
    parameter int RX_WORDS = 8,
    parameter int SPACE_W  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reg_flush,
    input  logic [PHY_NUM-1:0] reg_mask,
    input  logic [31:0]        reg_tout,
    input  logic [PHY_NUM-1:0] rx_phy_req,
    output logic [PHY_NUM-1:0] rx_phy_sel,
    output logic               rx_phy_start,
    input  logic               rx_phy_vld,
    input  logic [31:0]        rx_phy_dat,
    output logic               rx_phy_done,
    input  logic [SPACE_W-1:0] rx_fifo_space,
    output logic               rx_fifo_wr,
    output logic [31:0]        rx_fifo_dat,
    output logic [1:0]         cur_state,
    output logic [15:0]        rx_tout_cnt
);

    localparam int             CNT_W = $clog2(RX_WORDS + 1);
    localparam logic [SPACE_W:0] NEED = (SPACE_W + 1)'(RX_WORDS);

    rxc_state_e         state, state_nxt;
    logic [PHY_NUM-1:0] cand, win, sel_nxt;
    logic               start_nxt, done_nxt, wr_nxt, grant_go, last_word;
    logic [31:0]        dat_nxt, timer, timer_nxt;
    logic [32:0]        timer_inc;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [15:0]        tout_nxt;

    assign cand      = rx_phy_req & reg_mask;
    assign cur_state = state;
    assign last_word = (cnt == CNT_W'(RX_WORDS - 1));
    assign timer_inc = {1'b0, timer} + 33'd1;

    rxc_arb #(.N(PHY_NUM)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .flush (reg_flush),
        .cand  (cand),
        .grant (grant_go),
        .win   (win)
    );

    always_comb begin
        state_nxt = state;
        sel_nxt   = rx_phy_sel;
        start_nxt = 1'b0;
        done_nxt  = 1'b0;
        wr_nxt    = 1'b0;
        dat_nxt   = rx_fifo_dat;
        cnt_nxt   = cnt;
        timer_nxt = timer;
        tout_nxt  = rx_tout_cnt;
        grant_go  = 1'b0;
        case (state)
            // A pending write still has to show up in rx_fifo_space before we reserve again.
            ST_IDLE: begin
                if ((|cand) && ({1'b0, rx_fifo_space} >= NEED) && !rx_fifo_wr) begin
                    grant_go  = 1'b1;
                    sel_nxt   = win;
                    start_nxt = 1'b1;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                cnt_nxt   = '0;
                timer_nxt = '0;
                state_nxt = ST_RECV;
            end
            ST_RECV: begin
                if (rx_phy_vld) begin
                    wr_nxt    = 1'b1;
                    dat_nxt   = rx_phy_dat;
                    cnt_nxt   = cnt + 1'b1;
                    timer_nxt = '0;
                    if (last_word) begin
                        done_nxt  = 1'b1;
                        sel_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    timer_nxt = timer_inc[32] ? timer : timer_inc[31:0];
                    if ((reg_tout != 32'd0) && (timer_inc >= {1'b0, reg_tout})) begin
                        state_nxt = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                wr_nxt  = 1'b1;
                dat_nxt = FILL_WORD;
                cnt_nxt = cnt + 1'b1;
                if (last_word) begin
                    done_nxt  = 1'b1;
                    sel_nxt   = '0;
                    tout_nxt  = sat_inc16(rx_tout_cnt);
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || reg_flush) begin
            state        <= ST_IDLE;
            rx_phy_sel   <= '0;
            rx_phy_start <= 1'b0;
            rx_phy_done  <= 1'b0;
            rx_fifo_wr   <= 1'b0;
            rx_fifo_dat  <= '0;
            cnt          <= '0;
            timer        <= '0;
        end else begin
            state        <= state_nxt;
            rx_phy_sel   <= sel_nxt;
            rx_phy_start <= start_nxt;
            rx_phy_done  <= done_nxt;
            rx_fifo_wr   <= wr_nxt;
            rx_fifo_dat  <= dat_nxt;
            cnt          <= cnt_nxt;
            timer        <= timer_nxt;
        end
    end

    // The watchdog frame count survives a flush so software can still read it afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_tout_cnt <= '0;
        end else if (!reg_flush) begin
            rx_tout_cnt <= tout_nxt;
        end
    end

endmodule
